// File: rtl/gauss_frame_scheduler.sv
`default_nettype none
// ============================================================================
// gauss_frame_scheduler - paces one frame through the Gaussian filter (pad, flush, reset).
// Optional macro GAUSS_SCHED_ERR_EN adds a sticky err output.  Revision: 1.0
// ============================================================================
module gauss_frame_scheduler #(
  parameter int ROW_W     = 400,
  parameter int ROWS      = 300,
  parameter int PAD_LEN   = 2,
  parameter int FLUSH_LEN = 804,
  parameter int FILT_LAT  = 11,
  parameter int RST_LEN   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       src_valid,
  input  logic [7:0] src_din,
  output logic       src_rd_en,
  output logic [7:0] filt_din,
  output logic       filt_en,
  output logic       filt_rst,
  input  logic       dst_full,
  output logic       dst_wr_en,
  output logic       busy,
  output logic       frame_done,
  output logic [8:0] row_idx
`ifdef GAUSS_SCHED_ERR_EN
  ,
  output logic       err
`endif
);

  localparam int COL_W   = ($clog2(ROW_W + 1) > 9) ? $clog2(ROW_W + 1) : 9;
  localparam int PAD_W   = ($clog2(PAD_LEN + 1) > 3) ? $clog2(PAD_LEN + 1) : 3;
  localparam int FLUSH_W = ($clog2(FLUSH_LEN + 1) > 10) ? $clog2(FLUSH_LEN + 1) : 10;
  localparam int PRIME_W = ($clog2(FILT_LAT + 1) > 4) ? $clog2(FILT_LAT + 1) : 4;
  localparam int RST_W   = ($clog2(RST_LEN + 1) > 3) ? $clog2(RST_LEN + 1) : 3;

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(ROW_W - 1);
  localparam logic [8:0]         ROW_LAST   = 9'(ROWS - 1);
  localparam logic [PAD_W-1:0]   PAD_LAST   = PAD_W'(PAD_LEN - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_LEN - 1);
  localparam logic [PRIME_W-1:0] PRIME_FULL = PRIME_W'(FILT_LAT);
  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ROW   = 3'd1,
    PAD   = 3'd2,
    FLUSH = 3'd3,
    RESET = 3'd4
  } state_t;

  state_t               state;
  logic [COL_W-1:0]     col;
  logic [8:0]           row;
  logic [PAD_W-1:0]     pad_cnt;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic [PRIME_W-1:0]   prime_cnt;
  logic [RST_W-1:0]     rst_cnt;
  logic                 push;

  // A push is one enabled filter cycle; dst_full always wins over src_valid.
  always_comb begin
    push = 1'b0;
    unique case (state)
      ROW:         push = src_valid & ~dst_full;
      PAD, FLUSH:  push = ~dst_full;
      default:     push = 1'b0;
    endcase
  end

  assign filt_en   = push;
  assign src_rd_en = push & (state == ROW);
  assign filt_din  = src_rd_en ? src_din : 8'd0;
  assign dst_wr_en = push & (prime_cnt == PRIME_FULL);
  assign row_idx   = row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      pad_cnt    <= '0;
      flush_cnt  <= '0;
      prime_cnt  <= '0;
      rst_cnt    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      filt_rst   <= 1'b1;
    end else begin
      if (push && (prime_cnt != PRIME_FULL)) begin
        prime_cnt <= prime_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          filt_rst   <= 1'b0;
          frame_done <= 1'b0;
          if (start) begin
            state     <= ROW;
            col       <= '0;
            row       <= '0;
            prime_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        ROW: begin
          if (push) begin
            col <= col + 1'b1;
            if (col == COL_LAST) begin
              state   <= PAD;
              pad_cnt <= '0;
            end
          end
        end
        PAD: begin
          if (push) begin
            if (pad_cnt == PAD_LAST) begin
              pad_cnt <= '0;
              col     <= '0;
              if (row == ROW_LAST) begin
                state     <= FLUSH;
                flush_cnt <= '0;
              end else begin
                row   <= row + 1'b1;
                state <= ROW;
              end
            end else begin
              pad_cnt <= pad_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (push) begin
            if (flush_cnt == FLUSH_LAST) begin
              state      <= RESET;
              rst_cnt    <= '0;
              filt_rst   <= 1'b1;
              frame_done <= (RST_LAST == '0);
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
        end
        RESET: begin
          if (rst_cnt == RST_LAST) begin
            state      <= IDLE;
            filt_rst   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
          end else begin
            rst_cnt    <= rst_cnt + 1'b1;
            frame_done <= (RST_W'(rst_cnt + 1'b1) == RST_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GAUSS_SCHED_ERR_EN
  logic [9:0] wd_cnt;

  // Watchdog saturates at 1023 starved cycles; the next starved cycle flags err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if ((state == ROW) && !src_valid) begin
        if (wd_cnt == 10'h3FF) begin
          err <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
      if (start && (state != IDLE)) begin
        err <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gauss_frame_scheduler.sv
`default_nettype none
// ============================================================================
// tb_gauss_frame_scheduler - scoreboard bench for gauss_frame_scheduler (small frame geometry).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_gauss_frame_scheduler;

  localparam int ROW_W     = 8;
  localparam int ROWS      = 4;
  localparam int PAD_LEN   = 2;
  localparam int FLUSH_LEN = 20;
  localparam int FILT_LAT  = 11;
  localparam int RST_LEN   = 4;
  localparam int TOTAL     = ROWS * (ROW_W + PAD_LEN) + FLUSH_LEN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       src_valid = 1'b0;
  logic       dst_full = 1'b0;
  logic [7:0] src_din;
  logic [7:0] filt_din;
  logic       src_rd_en, filt_en, filt_rst, dst_wr_en, busy, frame_done;
  logic [8:0] row_idx;
`ifdef GAUSS_SCHED_ERR_EN
  logic       err;
`endif

  typedef struct packed {
    logic [7:0] pix;
    logic [8:0] row;   // 9'h1FF: row not checked (flush slots)
    logic       src;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   src_ptr = 0;
  int   en_cnt, wr_cnt, pop_cnt, rst_cyc, done_cnt, done_cyc;
  bit   ab;

  always #5 clk = ~clk;

  gauss_frame_scheduler #(
    .ROW_W(ROW_W), .ROWS(ROWS), .PAD_LEN(PAD_LEN),
    .FLUSH_LEN(FLUSH_LEN), .FILT_LAT(FILT_LAT), .RST_LEN(RST_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_valid(src_valid), .src_din(src_din), .src_rd_en(src_rd_en),
    .filt_din(filt_din), .filt_en(filt_en), .filt_rst(filt_rst),
    .dst_full(dst_full), .dst_wr_en(dst_wr_en), .busy(busy),
    .frame_done(frame_done), .row_idx(row_idx)
`ifdef GAUSS_SCHED_ERR_EN
    , .err(err)
`endif
  );

  function automatic logic [7:0] pix(input int k);
    return 8'((k * 37 + 11) & 255);
  endfunction

  // FWFT source model: head of the source stream is always on src_din.
  assign src_din = pix(src_ptr);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic sample_cycle(input int cyc);
    exp_t e;
    if (dst_full) check("stall_quiet", {29'd0, filt_en, src_rd_en, dst_wr_en}, 0);
    if (filt_rst) check("rst_quiet", filt_en, 0);
    if (src_rd_en) check("pop_valid", src_valid, 1);
    if (filt_en) begin
      if (exp_q.size() == 0) begin
        check("extra_push", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("filt_din", filt_din, e.pix);
        check("pop_slot", src_rd_en, e.src);
        if (e.row != 9'h1FF) check("row_idx", row_idx, e.row);
      end
      en_cnt++;
    end
    if (dst_wr_en) wr_cnt++;
    if (src_rd_en && src_valid) begin
      pop_cnt++;
      src_ptr++;
    end
    if (filt_rst) rst_cyc++;
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_in_rst", filt_rst, 1);
    end
  endtask

  // mode 0: steady, 1: 5-cycle stall in row 2, 2: src_valid toggling,
  // 3: random valid/full, 4: steady plus a start pulse mid-frame
  task automatic run_frame(input int mode, input int abort_rem, output bit aborted);
    int cyc;
    int base;
    int stall_left;
    bit stalled;
    en_cnt = 0; wr_cnt = 0; pop_cnt = 0; rst_cyc = 0; done_cnt = 0; done_cyc = 0;
    stall_left = 0; stalled = 0; aborted = 0;
    base = src_ptr;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < ROW_W; c++)
        exp_q.push_back(exp_t'{pix: pix(base + r * ROW_W + c), row: 9'(r), src: 1'b1});
      for (int p = 0; p < PAD_LEN; p++)
        exp_q.push_back(exp_t'{pix: 8'd0, row: 9'(r), src: 1'b0});
    end
    for (int f = 0; f < FLUSH_LEN; f++)
      exp_q.push_back(exp_t'{pix: 8'd0, row: 9'h1FF, src: 1'b0});

    @(negedge clk);
    start = 1'b1; src_valid = 1'b1; dst_full = 1'b0;
    cyc = 0;
    while (done_cnt == 0) begin
      @(negedge clk);
      cyc++;
      sample_cycle(cyc);
      if (cyc == 1) check("busy_on", busy, 1);
`ifdef GAUSS_SCHED_ERR_EN
      if (mode == 4 && cyc == 6) check("err_set", err, 1);
      if (mode == 4 && frame_done) check("err_sticky", err, 1);
      if (mode != 4) check("err_clear", err, 0);
`endif
      if (abort_rem >= 0 && exp_q.size() == abort_rem) begin
        aborted = 1;
        return;
      end
      if (cyc > 2000) begin
        check("timeout", 0, 1);
        exp_q.delete();
        return;
      end
      start = (mode == 4 && cyc == 5);
      case (mode)
        1: begin
          src_valid = 1'b1;
          if (!stalled && pop_cnt == 2 * ROW_W + 3) begin
            stalled = 1; stall_left = 5;
          end
          dst_full = (stall_left > 0);
          if (stall_left > 0) stall_left--;
        end
        2: begin src_valid = ~src_valid; dst_full = 1'b0; end
        3: begin
          src_valid = ($urandom_range(0, 3) != 0);
          dst_full  = ($urandom_range(0, 4) == 0);
        end
        default: begin src_valid = 1'b1; dst_full = 1'b0; end
      endcase
    end
    start = 1'b0; dst_full = 1'b0;
    @(negedge clk);
    sample_cycle(cyc + 1);
    check("busy_off", busy, 0);
    check("filt_rst_off", filt_rst, 0);
    check("done_once", done_cnt, 1);
    check("enables", en_cnt, TOTAL);
    check("writes", wr_cnt, TOTAL - FILT_LAT);
    check("pops", pop_cnt, ROWS * ROW_W);
    check("rst_len", rst_cyc, RST_LEN);
    check("queue_empty", exp_q.size(), 0);
    if (mode == 0) check("done_latency", done_cyc, TOTAL + RST_LEN);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_filt_rst", filt_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_filt_en", filt_en, 0);
    check("rst_src_rd", src_rd_en, 0);
    check("rst_wr", dst_wr_en, 0);
    check("rst_done", frame_done, 0);
    check("rst_row", row_idx, 0);
`ifdef GAUSS_SCHED_ERR_EN
    check("rst_err", err, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("filt_rst_release", filt_rst, 0);

    run_frame(0, -1, ab);
    run_frame(1, -1, ab);
    run_frame(2, -1, ab);
    run_frame(3, -1, ab);

    // Abort in the middle of FLUSH with an asynchronous reset
    run_frame(0, FLUSH_LEN / 2, ab);
    check("abort_reached", ab, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_filt_rst", filt_rst, 1);
    check("abort_busy", busy, 0);
    check("abort_filt_en", filt_en, 0);
    check("abort_src_rd", src_rd_en, 0);
    check("abort_wr", dst_wr_en, 0);
    check("abort_row", row_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_no_done", frame_done, 0);
    check("abort_idle_busy", busy, 0);
    run_frame(0, -1, ab);

`ifdef GAUSS_SCHED_ERR_EN
    run_frame(4, -1, ab);
    check("err_after_frame", err, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
